// File: rtl/mem_request_responder.sv
// Memory request responder: serializes instruction fetches and data loads/stores
// from the datapath onto one RAM port, with fixed data priority and an access watchdog.
module mem_request_responder #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC,
        RESP
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wd_count;
    logic        is_write;
    logic        acc_done;
    logic [31:0] resp_word;

    assign acc_done = ramready || (wd_count == WD_LAST);

    // Writes always return 0; a read returns RAM data, or ERRWORD if it timed out.
    always_comb begin
        resp_word = '0;
        if (!is_write) begin
            resp_word = ramready ? ramload : ERRWORD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            wd_count <= '0;
            is_write <= 1'b0;
            ihit     <= 1'b0;
            iload    <= '0;
            dhit     <= 1'b0;
            dload    <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            err      <= 1'b0;
        end else begin
            ihit  <= 1'b0;
            iload <= '0;
            dhit  <= 1'b0;
            dload <= '0;
            case (state)
                IDLE: begin
                    wd_count <= '0;
                    if (dREN || dWEN) begin
                        state    <= DACC;
                        is_write <= dWEN;
                        ramWEN   <= dWEN;
                        ramREN   <= !dWEN;
                        ramaddr  <= {daddr[31:2], 2'b00};
                        ramstore <= dWEN ? dstore : '0;
                    end else if (iREN) begin
                        state    <= IACC;
                        is_write <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramREN   <= 1'b1;
                        ramaddr  <= {iaddr[31:2], 2'b00};
                        ramstore <= '0;
                    end
                end
                DACC, IACC: begin
                    if (acc_done) begin
                        state    <= RESP;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= '0;
                        ramstore <= '0;
                        // ramready beats a coinciding timeout, so err only on a true expiry
                        if (!ramready) begin
                            err <= 1'b1;
                        end
                        if (state == DACC) begin
                            dhit  <= 1'b1;
                            dload <= resp_word;
                        end else begin
                            ihit  <= 1'b1;
                            iload <= resp_word;
                        end
                    end else begin
                        wd_count <= wd_count + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_responder.sv
// Directed bench for mem_request_responder: fixed vectors with hand-computed
// expectations, sampled 1ns after each rising edge.
module tb_mem_request_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ramready = 1'b0;
    logic        err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_request_responder #(
        .TIMEOUT(16),
        .ERRWORD(32'hBAD1BAD1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .iREN(iREN),
        .iaddr(iaddr),
        .dREN(dREN),
        .dWEN(dWEN),
        .daddr(daddr),
        .dstore(dstore),
        .ihit(ihit),
        .iload(iload),
        .dhit(dhit),
        .dload(dload),
        .ramREN(ramREN),
        .ramWEN(ramWEN),
        .ramaddr(ramaddr),
        .ramstore(ramstore),
        .ramload(ramload),
        .ramready(ramready),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait for dhit with ramready held low; count cycles with a strobe high.
    task automatic wait_dhit(output int unsigned strobe_cycles, output logic seen);
        strobe_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dhit) begin
                seen = 1'b1;
                break;
            end
            if (ramREN || ramWEN) strobe_cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got %h expected %h", 32'd0, 32'd1);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int unsigned n;
        logic seen;

        // Reset
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_dhit", {31'd0, dhit}, 32'd0);
        check("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_loads", iload | dload | ramstore, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // Single fetch, ramready in cycle 1
        iREN = 1'b1;
        iaddr = 32'h0000_0040;
        tick();
        check("if_ramREN", {31'd0, ramREN}, 32'd1);
        check("if_ramaddr", ramaddr, 32'h40);
        check("if_ihit_early", {31'd0, ihit}, 32'd0);
        ramready = 1'b1;
        ramload = 32'h2001_0005;
        tick();
        check("if_ihit", {31'd0, ihit}, 32'd1);
        check("if_iload", iload, 32'h2001_0005);
        check("if_dload", dload, 32'd0);
        check("if_ramREN_off", {31'd0, ramREN}, 32'd0);
        check("if_err", {31'd0, err}, 32'd0);
        ramready = 1'b0;
        iREN = 1'b0;
        tick();
        check("if_ihit_once", {31'd0, ihit}, 32'd0);
        check("if_iload_zero", iload, 32'd0);

        // Simultaneous fetch and store: data first, unaligned address
        iREN = 1'b1;
        iaddr = 32'h0000_0080;
        dWEN = 1'b1;
        daddr = 32'h0000_0103;
        dstore = 32'hCAFE_F00D;
        tick();
        check("pr_ramWEN", {31'd0, ramWEN}, 32'd1);
        check("pr_ramREN", {31'd0, ramREN}, 32'd0);
        check("pr_ramaddr", ramaddr, 32'h100);
        check("pr_ramstore", ramstore, 32'hCAFE_F00D);
        ramready = 1'b1;
        ramload = 32'hDEAD_BEEF;
        tick();
        check("pr_dhit", {31'd0, dhit}, 32'd1);
        check("pr_dload_wr", dload, 32'd0);
        check("pr_ihit", {31'd0, ihit}, 32'd0);
        dWEN = 1'b0;
        ramready = 1'b0;
        tick();
        check("pr_idle_strobe", {30'd0, ramREN, ramWEN}, 32'd0);
        check("pr_dhit_once", {31'd0, dhit}, 32'd0);
        tick();
        check("pr_i_ramREN", {31'd0, ramREN}, 32'd1);
        check("pr_i_ramaddr", ramaddr, 32'h80);
        check("pr_i_ramstore", ramstore, 32'd0);
        ramready = 1'b1;
        ramload = 32'h1234_5678;
        tick();
        check("pr_ihit", {31'd0, ihit}, 32'd1);
        check("pr_iload", iload, 32'h1234_5678);
        iREN = 1'b0;
        ramready = 1'b0;
        tick();

        // Read timeout
        dREN = 1'b1;
        daddr = 32'h0000_0300;
        wait_dhit(n, seen);
        check("to_seen", {31'd0, seen}, 32'd1);
        check("to_strobe_cycles", n, 32'd16);
        check("to_dload", dload, 32'hBAD1_BAD1);
        check("to_err", {31'd0, err}, 32'd1);
        dREN = 1'b0;
        tick();

        // Good read afterwards: err stays sticky
        dREN = 1'b1;
        daddr = 32'h0000_0008;
        tick();
        ramready = 1'b1;
        ramload = 32'h0000_0055;
        tick();
        check("ok_dhit", {31'd0, dhit}, 32'd1);
        check("ok_dload", dload, 32'h55);
        check("ok_err_sticky", {31'd0, err}, 32'd1);
        dREN = 1'b0;
        ramready = 1'b0;
        tick();

        // Write timeout: dhit with zero load
        dWEN = 1'b1;
        daddr = 32'h0000_0010;
        dstore = 32'h0BAD_F00D;
        wait_dhit(n, seen);
        check("wto_seen", {31'd0, seen}, 32'd1);
        check("wto_strobe_cycles", n, 32'd16);
        check("wto_dload", dload, 32'd0);
        dWEN = 1'b0;
        tick();

        // Address change mid-access is ignored
        dREN = 1'b1;
        daddr = 32'h0000_0104;
        tick();
        check("mid_ramaddr1", ramaddr, 32'h104);
        daddr = 32'h0000_0200;
        tick();
        check("mid_ramaddr2", ramaddr, 32'h104);
        tick();
        check("mid_ramaddr3", ramaddr, 32'h104);
        ramready = 1'b1;
        ramload = 32'h0000_A5A5;
        tick();
        check("mid_dhit", {31'd0, dhit}, 32'd1);
        check("mid_dload", dload, 32'hA5A5);
        dREN = 1'b0;
        ramready = 1'b0;
        tick();
        check("mid_dhit_once", {31'd0, dhit}, 32'd0);

        // Request dropped mid-access still completes
        dREN = 1'b1;
        daddr = 32'h0000_0020;
        tick();
        dREN = 1'b0;
        tick();
        ramready = 1'b1;
        ramload = 32'h0000_0777;
        tick();
        check("drop_dhit", {31'd0, dhit}, 32'd1);
        check("drop_dload", dload, 32'h777);
        ramready = 1'b0;
        tick();

        // Reset during IACC
        iREN = 1'b1;
        iaddr = 32'h0000_00C0;
        tick();
        check("ri_ramREN", {31'd0, ramREN}, 32'd1);
        RST = 1'b1;
        tick();
        check("ri_ramREN_off", {31'd0, ramREN}, 32'd0);
        check("ri_ihit", {31'd0, ihit}, 32'd0);
        check("ri_err_clr", {31'd0, err}, 32'd0);
        RST = 1'b0;
        tick();
        check("ri_ramaddr", ramaddr, 32'hC0);
        check("ri_ramREN_again", {31'd0, ramREN}, 32'd1);
        ramready = 1'b1;
        ramload = 32'h0000_0077;
        tick();
        check("ri_ihit2", {31'd0, ihit}, 32'd1);
        check("ri_iload2", iload, 32'h77);
        iREN = 1'b0;
        ramready = 1'b0;
        tick();

        // ramready on the last watchdog cycle wins over the timeout
        dREN = 1'b1;
        daddr = 32'h0000_0040;
        tick();
        for (int j = 1; j < 16; j++) tick();
        check("edge_ramREN16", {31'd0, ramREN}, 32'd1);
        ramready = 1'b1;
        ramload = 32'h0000_0099;
        tick();
        check("edge_dhit", {31'd0, dhit}, 32'd1);
        check("edge_dload", dload, 32'h99);
        check("edge_no_err", {31'd0, err}, 32'd0);
        dREN = 1'b0;
        ramready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
